// File: rtl/control_ws_pkg.sv
// Shared types for the control_ws sequencer.
//   opcode_t     : VeriRISC instruction opcodes.
//   ctrl_state_t : sequencer states; encodings 10..15 are illegal.
//   ctrl_t       : bundle of the seven datapath control lines.
//   is_aluop()   : opcodes that read an operand from memory.
package control_ws_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8,
        PAUSE      = 4'd9
    } ctrl_state_t;

    typedef struct packed {
        logic load_ac;
        logic mem_rd;
        logic mem_wr;
        logic inc_pc;
        logic load_pc;
        logic load_ir;
        logic halt;
    } ctrl_t;

    // Opcodes whose operand comes from memory (and therefore may wait on it).
    function automatic logic is_aluop(input opcode_t op);
        logic res;
        case (op)
            ADD, AND, XOR, LDA: res = 1'b1;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/control_ws_wait_timer.sv
// Counts consecutive not-ready cycles spent in a memory fetch state.
//   clk, rst_ : clock, async active-low reset
//   clr       : zero the count (sequencer not in a wait state)
//   en        : memory not ready this cycle; count one more wait cycle
//   timeout   : count has reached MAX_WAIT; one more not-ready cycle is fatal
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_r;

    assign timeout = (wait_cnt_r == MAX_WAIT_C);

    // Wait counter; saturates at MAX_WAIT since the sequencer leaves on timeout.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wait_cnt_r <= 8'd0;
        end else if (clr) begin
            wait_cnt_r <= 8'd0;
        end else if (en && !timeout) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: rtl/control_ws.sv
// VeriRISC sequencer with memory wait/timeout, halt/resume and single-step.
//   clk, rst_         : clock, async active-low reset
//   opcode, zero      : instruction opcode and accumulator zero flag
//   mem_ready         : memory read data valid this cycle
//   resume            : pulse, leaves HALTED (also clears mem_err)
//   step_en, step     : single-step enable (sampled in STORE), pulse leaves PAUSE
//   load_ac..halt     : registered datapath controls for the occupied state
//   mem_err           : sticky memory-timeout flag
//   instr_cnt         : retired-instruction counter, wraps
//   state_o           : current state for debug
module control_ws
    import control_ws_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  opcode_t          opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             resume,
    input  logic             step_en,
    input  logic             step,
    output logic             load_ac,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ir,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_cnt,
    output ctrl_state_t      state_o
);

    ctrl_state_t      state_r;
    ctrl_state_t      nstate_s;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_r;
    logic             aluop_s;
    logic             wait_s;
    logic             set_err_s;
    logic             timeout_s;
    logic             mem_err_r;
    logic [CNT_W-1:0] instr_cnt_r;

    assign aluop_s = is_aluop(opcode);

    ctrl_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_    (rst_),
        .clr     (!wait_s),
        .en      (wait_s && !mem_ready),
        .timeout (timeout_s)
    );

    // Next-state logic; wait_s marks states that hold for memory.
    always_comb begin
        nstate_s  = INST_ADDR;
        wait_s    = 1'b0;
        set_err_s = 1'b0;
        case (state_r)
            INST_ADDR:  nstate_s = INST_FETCH;
            INST_FETCH: begin
                wait_s = 1'b1;
                if (mem_ready) begin
                    nstate_s = INST_LOAD;
                end else if (timeout_s) begin
                    nstate_s  = HALTED;
                    set_err_s = 1'b1;
                end else begin
                    nstate_s = INST_FETCH;
                end
            end
            INST_LOAD:  nstate_s = IDLE;
            IDLE:       nstate_s = OP_ADDR;
            OP_ADDR:    nstate_s = (opcode == HLT) ? HALTED : OP_FETCH;
            OP_FETCH: begin
                if (!aluop_s) begin
                    nstate_s = ALU_OP;
                end else begin
                    wait_s = 1'b1;
                    if (mem_ready) begin
                        nstate_s = ALU_OP;
                    end else if (timeout_s) begin
                        nstate_s  = HALTED;
                        set_err_s = 1'b1;
                    end else begin
                        nstate_s = OP_FETCH;
                    end
                end
            end
            ALU_OP:     nstate_s = STORE;
            STORE:      nstate_s = step_en ? PAUSE : INST_ADDR;
            HALTED:     nstate_s = resume ? INST_ADDR : HALTED;
            PAUSE:      nstate_s = step ? INST_ADDR : PAUSE;
            default:    nstate_s = INST_ADDR;
        endcase
    end

    // Control decode from the state about to be entered, so the registered
    // outputs line up with the cycle that state is occupied.
    always_comb begin
        ctrl_s = '0;
        case (nstate_s)
            INST_FETCH: ctrl_s.mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                ctrl_s.mem_rd  = 1'b1;
                ctrl_s.load_ir = 1'b1;
            end
            OP_ADDR:    ctrl_s.inc_pc = 1'b1;
            OP_FETCH:   ctrl_s.mem_rd = aluop_s;
            ALU_OP: begin
                ctrl_s.mem_rd  = aluop_s;
                ctrl_s.load_ac = aluop_s;
                ctrl_s.inc_pc  = (opcode == SKZ) && zero;
                ctrl_s.load_pc = (opcode == JMP);
            end
            STORE: begin
                ctrl_s.mem_rd  = aluop_s;
                ctrl_s.load_ac = aluop_s;
                ctrl_s.inc_pc  = (opcode == JMP);
                ctrl_s.load_pc = (opcode == JMP);
                ctrl_s.mem_wr  = (opcode == STO);
            end
            HALTED:     ctrl_s.halt = 1'b1;
            default:    ctrl_s = '0;
        endcase
    end

    // State and registered control outputs.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= INST_ADDR;
            ctrl_r  <= '0;
        end else begin
            state_r <= nstate_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // Sticky timeout flag; cleared on the same edge that resume leaves HALTED.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_err_r <= 1'b0;
        end else if (set_err_s) begin
            mem_err_r <= 1'b1;
        end else if ((state_r == HALTED) && resume) begin
            mem_err_r <= 1'b0;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    // Retired-instruction counter: STORE always exits on the next edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            instr_cnt_r <= '0;
        end else if (state_r == STORE) begin
            instr_cnt_r <= instr_cnt_r + CNT_W'(1);
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign load_ac   = ctrl_r.load_ac;
    assign mem_rd    = ctrl_r.mem_rd;
    assign mem_wr    = ctrl_r.mem_wr;
    assign inc_pc    = ctrl_r.inc_pc;
    assign load_pc   = ctrl_r.load_pc;
    assign load_ir   = ctrl_r.load_ir;
    assign halt      = ctrl_r.halt;
    assign mem_err   = mem_err_r;
    assign instr_cnt = instr_cnt_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_control_ws.sv
// Directed bench for control_ws (MAX_WAIT=15, CNT_W=4).
module tb_control_ws;
    import control_ws_pkg::*;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RD   = 7'b0100000;
    localparam logic [6:0] C_IR   = 7'b0100010;
    localparam logic [6:0] C_PC   = 7'b0001000;
    localparam logic [6:0] C_AC   = 7'b1100000;
    localparam logic [6:0] C_LPC  = 7'b0000100;
    localparam logic [6:0] C_JST  = 7'b0001100;
    localparam logic [6:0] C_HALT = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_;
    opcode_t     opcode;
    logic        zero, mem_ready, resume, step_en, step;
    logic        load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt;
    logic        mem_err;
    logic [3:0]  instr_cnt;
    ctrl_state_t state_o;
    logic [6:0]  ctl;
    logic [3:0]  exp_cnt;
    int          checks = 0;
    int          errors = 0;

    assign ctl = {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt};

    control_ws #(.MAX_WAIT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume), .step_en(step_en), .step(step),
        .load_ac(load_ac), .mem_rd(mem_rd), .mem_wr(mem_wr), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_ir(load_ir), .halt(halt),
        .mem_err(mem_err), .instr_cnt(instr_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; opcode = ADD; zero = 1'b0; mem_ready = 1'b1;
        resume = 1'b0; step_en = 1'b0; step = 1'b0;
        #3;
        checks++;
        if ({state_o, ctl, mem_err, instr_cnt} !== {INST_ADDR, C_NONE, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset: state=%s ctl=%b err=%b cnt=%0d, expected INST_ADDR 0000000 0 0",
                     state_o.name(), ctl, mem_err, instr_cnt);
        end
        tick();
        rst_ = 1'b1;
        exp_cnt = 4'd0;
    endtask

    task automatic test_add();
        ctrl_state_t es[8] = '{INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, INST_ADDR};
        logic [6:0]  ec[8] = '{C_RD, C_IR, C_IR, C_PC, C_RD, C_AC, C_AC, C_NONE};
        opcode = ADD; mem_ready = 1'b1; step_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({state_o, ctl} !== {es[i], ec[i]}) begin
                errors++;
                $display("FAIL add cycle %0d: state=%s ctl=%b, expected %s %b",
                         i, state_o.name(), ctl, es[i].name(), ec[i]);
            end
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL add count: got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_lda_wait();
        logic        rdy[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ctrl_state_t es[11] = '{INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, OP_FETCH,
                                OP_FETCH, OP_FETCH, ALU_OP, STORE, INST_ADDR};
        logic [6:0]  ec[11] = '{C_RD, C_IR, C_IR, C_PC, C_RD, C_RD, C_RD, C_RD, C_AC, C_AC, C_NONE};
        opcode = LDA;
        for (int i = 0; i < 11; i++) begin
            mem_ready = rdy[i];
            tick();
            checks++;
            if ({state_o, ctl, mem_err} !== {es[i], ec[i], 1'b0}) begin
                errors++;
                $display("FAIL lda_wait cycle %0d: state=%s ctl=%b err=%b, expected %s %b 0",
                         i, state_o.name(), ctl, mem_err, es[i].name(), ec[i]);
            end
        end
        mem_ready = 1'b1;
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL lda_wait count: got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        opcode = ADD; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({state_o, ctl, mem_err} !== {INST_FETCH, C_RD, 1'b0}) begin
                errors++;
                $display("FAIL timeout fetch cycle %0d: state=%s ctl=%b err=%b, expected INST_FETCH %b 0",
                         i, state_o.name(), ctl, mem_err, C_RD);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step = (i == 2);
            tick();
            checks++;
            if ({state_o, ctl, mem_err} !== {HALTED, C_HALT, 1'b1}) begin
                errors++;
                $display("FAIL timeout halted %0d: state=%s ctl=%b err=%b, expected HALTED %b 1",
                         i, state_o.name(), ctl, mem_err, C_HALT);
            end
        end
        step = 1'b0; mem_ready = 1'b1; resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if ({state_o, ctl, mem_err, instr_cnt} !== {INST_ADDR, C_NONE, 1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL timeout resume: state=%s ctl=%b err=%b cnt=%0d, expected INST_ADDR 0000000 0 %0d",
                     state_o.name(), ctl, mem_err, instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_ready_wins();
        ctrl_state_t es[6] = '{INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE};
        logic [6:0]  ec[6] = '{C_IR, C_IR, C_PC, C_NONE, C_PC, C_NONE};
        opcode = SKZ; zero = 1'b1; mem_ready = 1'b0;
        tick();
        repeat (15) tick();
        checks++;
        if (state_o !== INST_FETCH) begin
            errors++;
            $display("FAIL ready_wins pre: state=%s expected INST_FETCH", state_o.name());
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({state_o, ctl, mem_err} !== {es[i], ec[i], 1'b0}) begin
                errors++;
                $display("FAIL ready_wins cycle %0d: state=%s ctl=%b err=%b, expected %s %b 0",
                         i, state_o.name(), ctl, mem_err, es[i].name(), ec[i]);
            end
        end
        tick();
        zero = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if ({state_o, instr_cnt} !== {INST_ADDR, exp_cnt}) begin
            errors++;
            $display("FAIL ready_wins end: state=%s cnt=%0d, expected INST_ADDR %0d",
                     state_o.name(), instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_hlt();
        ctrl_state_t es[5] = '{INST_FETCH, INST_LOAD, IDLE, OP_ADDR, HALTED};
        logic [6:0]  ec[5] = '{C_RD, C_IR, C_IR, C_PC, C_HALT};
        opcode = HLT; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({state_o, ctl} !== {es[i], ec[i]}) begin
                errors++;
                $display("FAIL hlt cycle %0d: state=%s ctl=%b, expected %s %b",
                         i, state_o.name(), ctl, es[i].name(), ec[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({state_o, ctl, mem_err} !== {HALTED, C_HALT, 1'b0}) begin
                errors++;
                $display("FAIL hlt hold %0d: state=%s ctl=%b err=%b, expected HALTED %b 0",
                         i, state_o.name(), ctl, mem_err, C_HALT);
            end
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if ({state_o, ctl, instr_cnt} !== {INST_ADDR, C_NONE, exp_cnt}) begin
            errors++;
            $display("FAIL hlt resume: state=%s ctl=%b cnt=%0d, expected INST_ADDR 0000000 %0d",
                     state_o.name(), ctl, instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_step();
        ctrl_state_t es[8] = '{INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, PAUSE};
        logic [6:0]  ec[8] = '{C_RD, C_IR, C_IR, C_PC, C_NONE, C_LPC, C_JST, C_NONE};
        opcode = JMP; mem_ready = 1'b1; step_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({state_o, ctl} !== {es[i], ec[i]}) begin
                errors++;
                $display("FAIL step cycle %0d: state=%s ctl=%b, expected %s %b",
                         i, state_o.name(), ctl, es[i].name(), ec[i]);
            end
        end
        exp_cnt = exp_cnt + 4'd1;
        for (int i = 0; i < 3; i++) begin
            resume = (i == 1);
            tick();
            checks++;
            if ({state_o, ctl, instr_cnt} !== {PAUSE, C_NONE, exp_cnt}) begin
                errors++;
                $display("FAIL step pause %0d: state=%s ctl=%b cnt=%0d, expected PAUSE 0000000 %0d",
                         i, state_o.name(), ctl, instr_cnt, exp_cnt);
            end
        end
        resume = 1'b0; step = 1'b1;
        tick();
        step = 1'b0; step_en = 1'b0;
        checks++;
        if ({state_o, instr_cnt} !== {INST_ADDR, exp_cnt}) begin
            errors++;
            $display("FAIL step release: state=%s cnt=%0d, expected INST_ADDR %0d",
                     state_o.name(), instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while waiting in INST_FETCH.
        opcode = ADD; mem_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (state_o !== INST_FETCH) begin
            errors++;
            $display("FAIL rst_wait pre: state=%s expected INST_FETCH", state_o.name());
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl, mem_err, instr_cnt} !== {INST_ADDR, C_NONE, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rst_wait: state=%s ctl=%b err=%b cnt=%0d, expected INST_ADDR 0000000 0 0",
                     state_o.name(), ctl, mem_err, instr_cnt);
        end
        tick();
        rst_ = 1'b1; mem_ready = 1'b1; step_en = 1'b1;
        exp_cnt = 4'd0;
        // Reset while in PAUSE.
        repeat (8) tick();
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if ({state_o, instr_cnt} !== {PAUSE, exp_cnt}) begin
            errors++;
            $display("FAIL rst_pause pre: state=%s cnt=%0d, expected PAUSE %0d",
                     state_o.name(), instr_cnt, exp_cnt);
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl, mem_err, instr_cnt} !== {INST_ADDR, C_NONE, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rst_pause: state=%s ctl=%b err=%b cnt=%0d, expected INST_ADDR 0000000 0 0",
                     state_o.name(), ctl, mem_err, instr_cnt);
        end
        tick();
        rst_ = 1'b1; step_en = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_wrap();
        opcode = ADD; mem_ready = 1'b1; step_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            repeat (8) tick();
            exp_cnt = exp_cnt + 4'd1;
            checks++;
            if ({state_o, instr_cnt} !== {INST_ADDR, exp_cnt}) begin
                errors++;
                $display("FAIL wrap instr %0d: state=%s cnt=%0d, expected INST_ADDR %0d",
                         k, state_o.name(), instr_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lda_wait();
        test_timeout();
        test_ready_wins();
        test_hlt();
        test_step();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
